nr_divider: RTL and testbench

- Sequential signed 32-bit non-restoring divider: the inverse operation of the team's bit-pair Booth multiplier, serving DIV in the ALU datapath.
- Accepts dividend and divisor with a start pulse, iterates one quotient bit per cycle, and returns {remainder, quotient} as one 64-bit word for the HI/LO registers.
- The sign convention matches the multiplier's signed operands. Quotient truncates toward zero; the remainder takes the sign of the dividend.

---
 rtl/nr_divider_pkg.sv | 17 +
 rtl/nr_div_step.sv | 28 ++
 rtl/nr_divider.sv | 164 ++++++++++++++++
 tb/tb_nr_divider.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nr_divider_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding, default
// operand width and the {remainder, quotient} field offsets in the result word.
package nr_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int QUO_LO        = 0;
    localparam int REM_HI        = 2 * DEFAULT_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ITER    = 3'd1,
        CORRECT = 3'd2,
        SIGN    = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift {A,Q} left, add or subtract the divisor
// magnitude depending on the sign of A, and shift in the new quotient bit.
module nr_div_step
    import nr_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH+1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH+1:0] a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] a_shift_s;

    // Shift, conditional add/subtract, quotient bit from the new sign of A
    always_comb begin
        a_shift_s = {a[WIDTH:0], q[WIDTH-1]};
        if (a[WIDTH+1] == 1'b0) begin
            a_next = a_shift_s - {1'b0, m};
        end else begin
            a_next = a_shift_s + {1'b0, m};
        end
        q_next = {q[WIDTH-2:0], ~a_next[WIDTH+1]};
    end

endmodule

// File: rtl/nr_divider.sv
// Sequential signed non-restoring divider returning {remainder, quotient};
// quotient truncates toward zero, remainder carries the dividend's sign.
module nr_divider
    import nr_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Unsigned magnitude; exact for the most-negative value when read unsigned
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        if (x[WIDTH-1]) begin
            return (~x) + ONE_W;
        end else begin
            return x;
        end
    endfunction

    state_t             state_r;
    logic [WIDTH+1:0]   a_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH:0]     m_r;
    logic [CNT_W-1:0]   count_r;
    logic               q_neg_r;
    logic               r_neg_r;
    logic               ovf_pend_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic               ovf_r;
    logic [2*WIDTH-1:0] result_r;

    logic [WIDTH+1:0]   a_step_s;
    logic [WIDTH-1:0]   q_step_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_r),
        .q      (q_r),
        .m      (m_r),
        .a_next (a_step_s),
        .q_next (q_step_s)
    );

    // Sign fix-up of the unsigned quotient and (already corrected) remainder
    always_comb begin
        if (q_neg_r) begin
            quo_s = (~q_r) + ONE_W;
        end else begin
            quo_s = q_r;
        end
        if (r_neg_r) begin
            rem_s = (~a_r[WIDTH-1:0]) + ONE_W;
        end else begin
            rem_s = a_r[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r    <= IDLE;
            a_r        <= {(WIDTH+2){1'b0}};
            q_r        <= {WIDTH{1'b0}};
            m_r        <= {(WIDTH+1){1'b0}};
            count_r    <= {CNT_W{1'b0}};
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            ovf_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
            result_r   <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        ovf_r <= 1'b0;
                        if (divisor == {WIDTH{1'b0}}) begin
                            result_r <= {dividend, {WIDTH{1'b1}}};
                            dz_r     <= 1'b1;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            dz_r       <= 1'b0;
                            a_r        <= {(WIDTH+2){1'b0}};
                            q_r        <= magnitude(dividend);
                            m_r        <= {1'b0, magnitude(divisor)};
                            q_neg_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_r    <= dividend[WIDTH-1];
                            ovf_pend_r <= (dividend == MOST_NEG) && (divisor == {WIDTH{1'b1}});
                            count_r    <= CNT_INIT;
                            busy_r     <= 1'b1;
                            state_r    <= ITER;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ITER: begin
                    a_r     <= a_step_s;
                    q_r     <= q_step_s;
                    count_r <= count_r - CNT_ONE;
                    if (count_r == CNT_ONE) begin
                        state_r <= CORRECT;
                    end else begin
                        state_r <= ITER;
                    end
                end
                CORRECT: begin
                    if (a_r[WIDTH+1]) begin
                        a_r <= a_r + {1'b0, m_r};
                    end else begin
                        a_r <= a_r;
                    end
                    state_r <= SIGN;
                end
                SIGN: begin
                    // The most-negative / -1 quotient wraps to itself; only the flag marks it
                    result_r[QUO_LO +: WIDTH]     <= quo_s;
                    result_r[2*WIDTH-1 -: WIDTH]  <= rem_s;
                    ovf_r   <= ovf_pend_r;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign div_by_zero = dz_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_nr_divider.sv
// Scoreboard bench for nr_divider: stimulus pushes expected {rem,quo}, flags and
// latency; a negedge monitor pops and compares whenever done is presented.
module tb_nr_divider;

    localparam int W = 32;

    logic           clock = 1'b0;
    logic           clear;
    logic           start;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           div_by_zero;
    logic           overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    nr_divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!clear && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",      result,                e.res);
                check("div_by_zero", 64'(div_by_zero),      64'(e.dz));
                check("overflow",    64'(overflow),         64'(e.ovf));
                check("latency",     64'(cyc - e.acc),      64'(e.lat));
                check("busy_at_done", 64'(busy),            64'd0);
            end
        end
    end

    task automatic wait_empty(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] dvd, input logic [31:0] dvs,
                       input logic [63:0] res, input logic edz, input logic eovf,
                       input int lat);
        @(negedge clock);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        sb.push_back('{res, edz, eovf, cyc, lat});
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (lat > 1) begin
            check("busy_after_start", 64'(busy),        64'd1);
            check("dz_cleared",       64'(div_by_zero), 64'd0);
            check("ovf_cleared",      64'(overflow),    64'd0);
        end
        wait_empty(100);
        repeat (3) @(negedge clock);
        check("held_result", result,           res);
        check("held_dz",     64'(div_by_zero), 64'(edz));
        check("held_ovf",    64'(overflow),    64'(eovf));
    endtask

    initial begin
        int c0;
        clear    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(negedge clock);
        check("rst_busy",   64'(busy),        64'd0);
        check("rst_done",   64'(done),        64'd0);
        check("rst_dz",     64'(div_by_zero), 64'd0);
        check("rst_ovf",    64'(overflow),    64'd0);
        check("rst_result", result,           64'd0);
        clear = 1'b0;

        run(32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 1'b0, 1'b0, 35);
        run(32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 1'b0, 35);
        run(32'd100,        32'hFFFFFFF9,   {32'h00000002, 32'hFFFFFFF2}, 1'b0, 1'b0, 35);
        run(32'd7,          32'd0,          {32'h00000007, 32'hFFFFFFFF}, 1'b1, 1'b0, 1);
        run(32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 1'b0, 1'b0, 35);
        run(32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 1'b0, 1'b1, 35);
        run(32'h80000000,   32'd2,          {32'h00000000, 32'hC0000000}, 1'b0, 1'b0, 35);
        run(32'h80000000,   32'd1,          {32'h00000000, 32'h80000000}, 1'b0, 1'b0, 35);
        run(32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'h00000003}, 1'b0, 1'b0, 35);
        run(32'd0,          32'd5,          {32'h00000000, 32'h00000000}, 1'b0, 1'b0, 35);
        run(32'd3,          32'd10,         {32'h00000003, 32'h00000000}, 1'b0, 1'b0, 35);
        run(32'h7FFFFFFF,   32'd1,          {32'h00000000, 32'h7FFFFFFF}, 1'b0, 1'b0, 35);

        // Abort mid-operation: no done may follow, outputs return to zero
        @(negedge clock);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        check("busy_before_clear", 64'(busy), 64'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("abort_busy",   64'(busy),        64'd0);
        check("abort_done",   64'(done),        64'd0);
        check("abort_dz",     64'(div_by_zero), 64'd0);
        check("abort_ovf",    64'(overflow),    64'd0);
        check("abort_result", result,           64'd0);
        run(32'd9, 32'd4, {32'h00000001, 32'h00000002}, 1'b0, 1'b0, 35);

        // Start held high: second pair while busy is ignored, then accepted in IDLE after DONE
        @(negedge clock);
        c0       = cyc;
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd2;
        sb.push_back('{{32'h00000001, 32'h00000002}, 1'b0, 1'b0, c0, 35});
        sb.push_back('{{32'h00000002, 32'h00000003}, 1'b0, 1'b0, c0 + 36, 35});
        @(negedge clock);
        dividend = 32'd20;
        divisor  = 32'd6;
        while (cyc < c0 + 37) @(negedge clock);
        start = 1'b0;
        wait_empty(120);
        repeat (3) @(negedge clock);
        check("held_start_final", result, {32'h00000002, 32'h00000003});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
